// File: rtl/evm_pkg.sv
// Shared types and constants for the EVM ballot unit: FSM states, party codes,
// the vote counter ceiling and a one-hot test.
package evm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StSend,
    StReleaseOk,
    StReleaseInv
  } evm_state_e;

  localparam logic [2:0] P1       = 3'b001;
  localparam logic [2:0] P2       = 3'b010;
  localparam logic [2:0] P3       = 3'b100;
  localparam logic [6:0] VOTE_MAX = 7'd127;

  function automatic logic is_onehot(input logic [2:0] v);
    return (v == P1) || (v == P2) || (v == P3);
  endfunction

endpackage

// File: rtl/evm_btn_debounce.sv
// Two-flop synchronizer plus stability filter for the party-button bus; the
// debounced pattern follows the synchronized value once it has held DB_CYCLES cycles.
module evm_btn_debounce #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned W         = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_db
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DB_CYCLES - 1);

  logic [W-1:0]  r_s1;
  logic [W-1:0]  r_s2;
  logic [W-1:0]  r_db;
  logic [CW-1:0] r_cnt;

  // r_s1 is the value r_s2 takes next, so equality means r_s2 is holding steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_db  <= '0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s1 != r_s2) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        r_db <= r_s2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/evm_ballot_unit.sv
// Voter-side ballot unit: arms one ballot per officer issue, debounces the party
// buttons and hands exactly one one-hot vote to the counting unit over valid/ready.
module evm_ballot_unit
  import evm_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ballot_issue,
  input  logic [2:0] i_party_btn,
  input  logic       i_vote_ready,
  output logic       o_vote_valid,
  output logic [2:0] o_vote_code,
  output logic       o_ready_led,
  output logic       o_invalid,
  output logic       o_timeout,
  output logic [6:0] o_voters_served
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMax = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    w_db;
  evm_state_e    r_state, w_state_d;
  logic [TW-1:0] r_tcnt, w_tcnt_d;
  logic [2:0]    r_code, w_code_d;
  logic          r_invalid, w_invalid_d;
  logic          r_timeout, w_timeout_d;
  logic [6:0]    r_served, w_served_d;

  evm_btn_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .W        (3)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .i_raw(i_party_btn),
    .o_db (w_db)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_tcnt    <= '0;
      r_code    <= '0;
      r_invalid <= 1'b0;
      r_timeout <= 1'b0;
      r_served  <= '0;
    end else begin
      r_state   <= w_state_d;
      r_tcnt    <= w_tcnt_d;
      r_code    <= w_code_d;
      r_invalid <= w_invalid_d;
      r_timeout <= w_timeout_d;
      r_served  <= w_served_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_tcnt_d    = r_tcnt;
    w_code_d    = r_code;
    w_invalid_d = 1'b0;
    w_timeout_d = 1'b0;
    w_served_d  = r_served;
    unique case (r_state)
      StIdle: begin
        if (i_ballot_issue) begin
          w_state_d = StArmed;
          w_tcnt_d  = '0;
        end
      end
      StArmed: begin
        if (r_tcnt != TMax) w_tcnt_d = r_tcnt + TW'(1);
        // A press wins over an expiring ballot in the same cycle.
        if (is_onehot(w_db)) begin
          w_state_d = StSend;
          w_code_d  = w_db;
        end else if (w_db != 3'b000) begin
          w_state_d   = StReleaseInv;
          w_invalid_d = 1'b1;
        end else if (r_tcnt == TMax) begin
          w_state_d   = StIdle;
          w_timeout_d = 1'b1;
        end
      end
      StSend: begin
        if (i_vote_ready) begin
          w_state_d = StReleaseOk;
          if (r_served != VOTE_MAX) w_served_d = r_served + 7'd1;
        end
      end
      StReleaseOk: begin
        if (w_db == 3'b000) w_state_d = StIdle;
      end
      StReleaseInv: begin
        // Retry keeps the remaining ballot time.
        if (w_db == 3'b000) w_state_d = StArmed;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign o_vote_valid    = (r_state == StSend);
  assign o_vote_code     = o_vote_valid ? r_code : 3'b000;
  assign o_ready_led     = (r_state == StArmed);
  assign o_invalid       = r_invalid;
  assign o_timeout       = r_timeout;
  assign o_voters_served = r_served;

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Directed bench for evm_ballot_unit with DB_CYCLES=4, TIMEOUT_CYCLES=20;
// outputs are sampled on the falling edge, inputs change there too.
module tb_evm_ballot_unit;

  logic       clk;
  logic       rst_n;
  logic       ballot_issue;
  logic [2:0] party_btn;
  logic       vote_ready;
  logic       vote_valid;
  logic [2:0] vote_code;
  logic       ready_led;
  logic       invalid;
  logic       timeout;
  logic [6:0] voters_served;

  int n_checks = 0;
  int n_fail   = 0;

  evm_ballot_unit #(
    .DB_CYCLES     (4),
    .TIMEOUT_CYCLES(20)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_ballot_issue (ballot_issue),
    .i_party_btn    (party_btn),
    .i_vote_ready   (vote_ready),
    .o_vote_valid   (vote_valid),
    .o_vote_code    (vote_code),
    .o_ready_led    (ready_led),
    .o_invalid      (invalid),
    .o_timeout      (timeout),
    .o_voters_served(voters_served)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue_ballot();
    ballot_issue = 1'b1;
    @(negedge clk);
    ballot_issue = 1'b0;
  endtask

  task automatic release_wait();
    party_btn = 3'b000;
    repeat (9) @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (vote_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_vote(input logic [2:0] code, output bit ok);
    bit seen;
    vote_ready = 1'b1;
    issue_ballot();
    party_btn = code;
    wait_valid(12, seen);
    ok = seen && (vote_code == code);
    @(negedge clk);
    release_wait();
  endtask

  initial begin
    bit          seen;
    bit          ok;
    int          nvotes;
    int          ok_cnt;
    logic [2:0]  code_seen;

    rst_n        = 1'b0;
    ballot_issue = 1'b0;
    party_btn    = 3'b000;
    vote_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", vote_valid, 0);
    check_eq("rst_code", vote_code, 0);
    check_eq("rst_led", ready_led, 0);
    check_eq("rst_served", voters_served, 0);
    check_eq("rst_invalid", invalid, 0);
    check_eq("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single vote: valid exactly 7 edges after the press, one cycle wide.
    vote_ready = 1'b1;
    issue_ballot();
    check_eq("sv_led", ready_led, 1);
    party_btn = 3'b010;
    repeat (6) @(negedge clk);
    check_eq("sv_early", vote_valid, 0);
    @(negedge clk);
    check_eq("sv_valid", vote_valid, 1);
    check_eq("sv_code", vote_code, 3'b010);
    check_eq("sv_served0", voters_served, 0);
    @(negedge clk);
    check_eq("sv_drop", vote_valid, 0);
    check_eq("sv_code0", vote_code, 0);
    check_eq("sv_served1", voters_served, 1);
    release_wait();
    check_eq("sv_idle_led", ready_led, 0);
    check_eq("sv_idle_valid", vote_valid, 0);

    // Backpressure: code held while ready is low.
    vote_ready = 1'b0;
    issue_ballot();
    party_btn = 3'b010;
    wait_valid(12, seen);
    check_eq("bp_seen", seen, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_hold_code", vote_code, 3'b010);
      check_eq("bp_hold_served", voters_served, 1);
    end
    vote_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_drop", vote_valid, 0);
    check_eq("bp_served", voters_served, 2);
    release_wait();

    // Invalid press, release, then retry.
    issue_ballot();
    party_btn = 3'b011;
    repeat (7) @(negedge clk);
    check_eq("inv_pulse", invalid, 1);
    check_eq("inv_led", ready_led, 0);
    check_eq("inv_valid", vote_valid, 0);
    party_btn = 3'b000;
    @(negedge clk);
    check_eq("inv_pulse_end", invalid, 0);
    check_eq("inv_served", voters_served, 2);
    repeat (6) @(negedge clk);
    check_eq("inv_rearm", ready_led, 1);
    party_btn = 3'b100;
    wait_valid(12, seen);
    check_eq("inv_retry_seen", seen, 1);
    check_eq("inv_retry_code", vote_code, 3'b100);
    @(negedge clk);
    check_eq("inv_retry_served", voters_served, 3);
    release_wait();

    // Bounce: toggling every 2 cycles must not vote; the final hold votes once.
    issue_ballot();
    nvotes    = 0;
    code_seen = 3'b000;
    for (int i = 0; i < 10; i++) begin
      party_btn = (((i / 2) % 2) == 0) ? 3'b001 : 3'b000;
      @(negedge clk);
      if (vote_valid) nvotes++;
    end
    party_btn = 3'b001;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (vote_valid) begin
        nvotes++;
        code_seen = vote_code;
      end
    end
    check_eq("bnc_votes", nvotes, 1);
    check_eq("bnc_code", code_seen, 3'b001);
    check_eq("bnc_served", voters_served, 4);
    release_wait();

    // Timeout 20 edges after ARMED entry; later press is ignored.
    issue_ballot();
    repeat (19) @(negedge clk);
    check_eq("to_early", timeout, 0);
    check_eq("to_led_armed", ready_led, 1);
    @(negedge clk);
    check_eq("to_pulse", timeout, 1);
    check_eq("to_led_off", ready_led, 0);
    @(negedge clk);
    check_eq("to_pulse_end", timeout, 0);
    party_btn = 3'b001;
    nvotes    = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (vote_valid) nvotes++;
    end
    check_eq("to_no_vote", nvotes, 0);
    check_eq("to_served", voters_served, 4);
    release_wait();

    // Saturation: 126 more accepted votes make 130 in total.
    ok_cnt = 0;
    for (int i = 0; i < 126; i++) begin
      do_vote(3'b100, ok);
      if (ok) ok_cnt++;
    end
    check_eq("sat_votes_ok", ok_cnt, 126);
    check_eq("sat_served", voters_served, 127);

    // Reset mid-handshake clears everything immediately.
    vote_ready = 1'b0;
    issue_ballot();
    party_btn = 3'b010;
    wait_valid(12, seen);
    check_eq("rmh_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rmh_valid", vote_valid, 0);
    check_eq("rmh_code", vote_code, 0);
    check_eq("rmh_served", voters_served, 0);
    check_eq("rmh_led", ready_led, 0);
    check_eq("rmh_invalid", invalid, 0);
    check_eq("rmh_timeout", timeout, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    party_btn = 3'b000;
    repeat (2) @(negedge clk);
    check_eq("rmh_after_served", voters_served, 0);
    check_eq("rmh_after_led", ready_led, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
